// File: rtl/cordic_polar_post_if.sv
// Handshake and sample bundle between the vectoring CORDIC, the polar
// post-processing stage and its consumer.
interface cordic_polar_post_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic [W-1:0] mag_in;
  logic [W-1:0] theta_in;
  logic         in_ack;
  logic         out_valid;
  logic [W-1:0] mag_out;
  logic [W-1:0] theta_deg_out;
  logic         out_ack;

  modport master (
    output in_valid, mag_in, theta_in, out_ack,
    input  in_ack, out_valid, mag_out, theta_deg_out
  );

  modport slave (
    input  in_valid, mag_in, theta_in, out_ack,
    output in_ack, out_valid, mag_out, theta_deg_out
  );
endinterface

// File: rtl/cordic_polar_post.sv
// Removes the CORDIC gain from the raw magnitude and converts the angle from
// radians to degrees using two bit-serial shift-add constant multipliers.
module cordic_polar_post #(
  parameter int           W         = 16,
  parameter logic [W-1:0] KINV      = 16'h26DD,
  parameter logic [W-1:0] DEG_K     = 16'h394C,
  parameter int           MAG_SHIFT = 14,
  parameter int           DEG_SHIFT = 15
) (
  input logic               clk,
  input logic               rst_n,
  cordic_polar_post_if.slave bus
);

  localparam int AW = 32;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state, state_nxt;
  logic                 armed;
  logic [3:0]           cnt;
  logic                 mul_last;
  logic signed [W-1:0]  op_m, op_t;
  logic signed [AW-1:0] acc_m, acc_t;
  logic signed [AW-1:0] term_m, term_t;
  logic signed [AW-1:0] rnd_m, rnd_t;
  logic                 capture;

  assign capture = (state == IDLE) && bus.in_valid && armed;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture)     state_nxt = MUL;
      MUL:     if (mul_last)    state_nxt = DONE;
      DONE:    if (bus.out_ack) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // in_ack marks the single cycle following the capture edge; cnt wraps back
  // to zero on the finishing cycle, so mul_last distinguishes the two.
  always_comb begin
    bus.in_ack    = (state == MUL) && (cnt == 4'd0) && !mul_last;
    bus.out_valid = (state == DONE);
  end

  // Partial products: operand sign-extended, weighted by the current bit index.
  always_comb begin
    term_m = AW'(op_m) <<< cnt;
    term_t = AW'(op_t) <<< cnt;
  end

  // Round half up; the arithmetic shift floors negative results.
  always_comb begin
    rnd_m = (acc_m + (AW'(1) <<< (MAG_SHIFT - 1))) >>> MAG_SHIFT;
    rnd_t = (acc_t + (AW'(1) <<< (DEG_SHIFT - 1))) >>> DEG_SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed             <= 1'b0;
      cnt               <= '0;
      mul_last          <= 1'b0;
      op_m              <= '0;
      op_t              <= '0;
      acc_m             <= '0;
      acc_t             <= '0;
      bus.mag_out       <= '0;
      bus.theta_deg_out <= '0;
    end else begin
      // armed only re-arms once upstream valid has been seen low, so a valid
      // level that outlives in_ack is not captured twice.
      if (capture)            armed <= 1'b0;
      else if (!bus.in_valid) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (capture) begin
            op_m     <= bus.mag_in;
            op_t     <= bus.theta_in;
            acc_m    <= '0;
            acc_t    <= '0;
            cnt      <= '0;
            mul_last <= 1'b0;
          end
        end
        MUL: begin
          if (!mul_last) begin
            if (KINV[cnt])  acc_m <= acc_m + term_m;
            if (DEG_K[cnt]) acc_t <= acc_t + term_t;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) mul_last <= 1'b1;
          end else begin
            bus.mag_out       <= rnd_m[W-1:0];
            bus.theta_deg_out <= rnd_t[W-1:0];
            mul_last          <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_polar_post.sv
// Scoreboard bench for cordic_polar_post: directed vectors plus a polar sweep
// checked against real-valued sqrt/atan2.
module tb_cordic_polar_post;

  localparam real K_GAIN = 1.6467602581210656;
  localparam real PI     = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_polar_post_if #(.W(16)) bus ();

  cordic_polar_post dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cap_cyc = 0;
  int ack_cnt = 0;
  bit auto_ack  = 1'b1;
  bit force_ack = 1'b0;

  logic [15:0] q_mag[$];
  logic [15:0] q_deg[$];
  bit          q_tol[$];
  real         q_rm[$];
  real         q_rd[$];

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer side: acknowledge in the first valid cycle unless held off.
  initial begin
    bus.out_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ack = (auto_ack && bus.out_valid) || force_ack;
    end
  end

  // Monitor: records capture pulses and scores each new result.
  initial begin
    bit prev_ack = 1'b0;
    bit prev_ov  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.in_ack && !prev_ack) begin
        ack_cnt++;
        cap_cyc = cyc;
      end
      if (bus.out_valid && !prev_ov) begin
        if (q_mag.size() == 0) begin
          check("unexpected_result", 1'b0, 1, 0);
        end else begin
          logic [15:0] em, ed;
          bit tol;
          real rm, rd, dm, dd;
          em = q_mag.pop_front();
          ed = q_deg.pop_front();
          tol = q_tol.pop_front();
          rm = q_rm.pop_front();
          rd = q_rd.pop_front();
          check("latency", (cyc - cap_cyc) == 17, cyc - cap_cyc, 17);
          if (tol) begin
            dm = $itor($signed(bus.mag_out)) - rm;
            dd = ($itor($signed(bus.theta_deg_out)) - rd) / 128.0;
            check("sweep_mag", (dm <= 1.000001) && (dm >= -1.000001),
                  longint'($signed(bus.mag_out)), longint'(int'(rm)));
            check("sweep_deg_x128", (dd <= 0.1) && (dd >= -0.1),
                  longint'($signed(bus.theta_deg_out)), longint'(int'(rd)));
          end else begin
            check("mag_out", bus.mag_out == em, bus.mag_out, em);
            check("theta_deg_out", bus.theta_deg_out == ed, bus.theta_deg_out, ed);
          end
        end
      end
      prev_ack = bus.in_ack;
      prev_ov  = bus.out_valid;
    end
  end

  task automatic push_exp(input logic [15:0] em, ed, input bit tol, input real rm, rd);
    q_mag.push_back(em);
    q_deg.push_back(ed);
    q_tol.push_back(tol);
    q_rm.push_back(rm);
    q_rd.push_back(rd);
  endtask

  // Drops in_valid for one edge (arming the guard), raises it, waits for in_ack.
  task automatic issue(input logic [15:0] m, th, input bit drop_after);
    bit got = 1'b0;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    bus.mag_in   = m;
    bus.theta_in = th;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #2;
      if (bus.in_ack) got = 1'b1;
    end
    check("in_ack_timeout", got, got, 1);
    if (drop_after) bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] m, th, em, ed);
    push_exp(em, ed, 1'b0, 0.0, 0.0);
    issue(m, th, 1'b1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk); #2;
      if (q_mag.size() == 0 && !bus.out_valid) ok = 1'b1;
    end
    check("drain_timeout", ok, ok, 1);
  endtask

  initial begin
    real xs[10];
    real ys[10];
    logic [15:0] snap_m, snap_d;
    int viol, acks0, ovs;
    bit got;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    real xs[10];
    real ys[10];
    logic [15:0] snap_m, snap_d;
    int viol, acks0, ovs;
    bit got;

    bus.in_valid = 1'b0;
    bus.mag_in   = '0;
    bus.theta_in = '0;
    #3;
    check("rst_in_ack",    bus.in_ack == 1'b0,      bus.in_ack, 0);
    check("rst_out_valid", bus.out_valid == 1'b0,   bus.out_valid, 0);
    check("rst_mag_out",   bus.mag_out == 16'h0,    bus.mag_out, 0);
    check("rst_theta_out", bus.theta_deg_out == 16'h0, bus.theta_deg_out, 0);
    #20 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Gain removal and angle conversion.
    send(16'h4000, 16'h0000, 16'h26DD, 16'h0000);
    send(16'h4000, 16'h3244, 16'h26DD, 16'h1680);
    send(16'h4000, 16'hCDBC, 16'h26DD, 16'hE980);
    send(16'h4000, 16'h6488, 16'h26DD, 16'h2D00);
    wait_done();

    // Double-capture guard: valid stays high across the whole transaction.
    acks0 = ack_cnt;
    push_exp(16'h136F, 16'h0000, 1'b0, 0.0, 0.0);
    issue(16'h2000, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    check("guard_acks_hold3", ack_cnt - acks0 == 1, ack_cnt - acks0, 1);
    wait_done();
    repeat (5) @(posedge clk);
    check("guard_acks_held", ack_cnt - acks0 == 1, ack_cnt - acks0, 1);
    send(16'h1000, 16'hF000, 16'h09B7, 16'hF8D7);
    wait_done();
    check("guard_rearm", ack_cnt - acks0 == 2, ack_cnt - acks0, 2);

    // Back-pressure: result A held while B waits upstream.
    auto_ack = 1'b0;
    send(16'h4000, 16'h3244, 16'h26DD, 16'h1680);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #2;
      if (bus.out_valid) got = 1'b1;
    end
    check("bp_valid_timeout", got, got, 1);
    snap_m = bus.mag_out;
    snap_d = bus.theta_deg_out;
    push_exp(16'hD923, 16'h2D00, 1'b0, 0.0, 0.0);
    bus.mag_in   = 16'hC000;
    bus.theta_in = 16'h6488;
    bus.in_valid = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (bus.in_ack || !bus.out_valid || bus.mag_out != snap_m ||
          bus.theta_deg_out != snap_d) viol++;
    end
    check("bp_hold_stable", viol == 0, viol, 0);
    force_ack = 1'b1;
    @(posedge clk); #2;
    force_ack = 1'b0;
    auto_ack  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #2;
      if (bus.in_ack) got = 1'b1;
    end
    check("bp_second_capture", got, got, 1);
    bus.in_valid = 1'b0;
    wait_done();
    check("bp_mag_retained", bus.mag_out == 16'hD923, bus.mag_out, 16'hD923);

    // Reset in the middle of the multiply (counter = 7).
    issue(16'h4000, 16'h3244, 1'b1);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
    check("midrst_in_ack",    bus.in_ack == 1'b0,    bus.in_ack, 0);
    check("midrst_mag_out",   bus.mag_out == 16'h0,  bus.mag_out, 0);
    check("midrst_theta_out", bus.theta_deg_out == 16'h0, bus.theta_deg_out, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    ovs = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #2;
      if (bus.out_valid) ovs++;
    end
    check("midrst_no_result", ovs == 0, ovs, 0);

    // Back-to-back polar sweep, raw inputs built from an ideal CORDIC.
    xs = '{0.5, 0.3, 0.4, 0.0, 0.0, -0.1, 0.25, 0.1, 0.45, -0.12};
    ys = '{0.0, 0.4, -0.3, 0.5, -0.5, 0.45, 0.25, -0.2, 0.05, -0.4};
    for (int i = 0; i < 10; i++) begin
      real r, a;
      int raw_m, raw_t;
      r = $sqrt(xs[i] * xs[i] + ys[i] * ys[i]);
      a = $atan2(ys[i], xs[i]);
      raw_m = int'(r * K_GAIN * 16384.0);
      raw_t = int'(a * 16384.0);
      push_exp(16'h0, 16'h0, 1'b1, r * 16384.0, a * 180.0 / PI * 128.0);
      issue(raw_m[15:0], raw_t[15:0], 1'b1);
    end
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
